// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: colour bars, checkerboard, grey ramp, bouncing box.
// One-cycle registered RGB with delayed DE; mode and animation change only at frame end.
module vga_pattern_gen #(
  parameter int unsigned H_ACT      = 640,
  parameter int unsigned V_ACT      = 480,
  parameter int unsigned COLOR_W    = 4,
  parameter int unsigned NUM_BARS   = 8,
  parameter int unsigned CHECK_LOG2 = 5,
  parameter int unsigned BOX_SIZE   = 32,
  parameter int unsigned BOX_STEP   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               DE,
  input  logic [9:0]         x_pixel,
  input  logic [9:0]         y_pixel,
  input  logic [1:0]         mode_sel,
  input  logic               pause,
  output logic               de_out,
  output logic [COLOR_W-1:0] r_port,
  output logic [COLOR_W-1:0] g_port,
  output logic [COLOR_W-1:0] b_port,
  output logic [15:0]        frame_cnt
);

  localparam int unsigned CW    = 10;
  localparam int unsigned BIW   = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam int unsigned BAR_W = H_ACT / NUM_BARS;
  localparam int unsigned GSTEP = H_ACT >> COLOR_W;

  localparam logic [10:0] BX_MAX = 11'(H_ACT - BOX_SIZE);
  localparam logic [10:0] BY_MAX = 11'(V_ACT - BOX_SIZE);
  localparam logic [10:0] STEP   = 11'(BOX_STEP);
  localparam logic [10:0] BSIZE  = 11'(BOX_SIZE);

  logic [1:0]         mode_q;
  logic [CW-1:0]      bar_cnt, bar_cnt_cur, bar_cnt_nxt;
  logic [BIW-1:0]     bar_idx, bar_idx_cur, bar_idx_nxt;
  logic [CW-1:0]      gr_cnt, gr_cnt_cur, gr_cnt_nxt;
  logic [COLOR_W-1:0] gr_lvl, gr_lvl_cur, gr_lvl_nxt;
  logic [10:0]        box_x, box_y, box_x_nxt, box_y_nxt;
  logic               dir_x, dir_y, dir_x_nxt, dir_y_nxt;
  logic               fe_c, in_box_c, chk_c;
  logic [2:0]         bar_col_c;
  logic [2:0]         bar_rgb_c;
  logic [COLOR_W-1:0] r_c, g_c, b_c;

  // Column counters restart at x==0 so bar/ramp index tracks the column without a divider
  always_comb begin
    fe_c        = DE && (x_pixel == 10'(H_ACT - 1)) && (y_pixel == 10'(V_ACT - 1));
    bar_cnt_cur = (x_pixel == '0) ? '0 : bar_cnt;
    bar_idx_cur = (x_pixel == '0) ? '0 : bar_idx;
    gr_cnt_cur  = (x_pixel == '0) ? '0 : gr_cnt;
    gr_lvl_cur  = (x_pixel == '0) ? '0 : gr_lvl;

    bar_cnt_nxt = bar_cnt_cur + 1'b1;
    bar_idx_nxt = bar_idx_cur;
    if (bar_cnt_cur == CW'(BAR_W - 1)) begin
      bar_cnt_nxt = '0;
      if (bar_idx_cur != BIW'(NUM_BARS - 1)) bar_idx_nxt = bar_idx_cur + 1'b1;
    end

    gr_cnt_nxt = gr_cnt_cur + 1'b1;
    gr_lvl_nxt = gr_lvl_cur;
    if (gr_cnt_cur == CW'(GSTEP - 1)) begin
      gr_cnt_nxt = '0;
      if (gr_lvl_cur != '1) gr_lvl_nxt = gr_lvl_cur + 1'b1;
    end
  end

  // Pixel colour for the current mode
  always_comb begin
    bar_col_c = 3'(bar_idx_cur);
    case (bar_col_c)
      3'd0:    bar_rgb_c = 3'b111;
      3'd1:    bar_rgb_c = 3'b110;
      3'd2:    bar_rgb_c = 3'b011;
      3'd3:    bar_rgb_c = 3'b010;
      3'd4:    bar_rgb_c = 3'b101;
      3'd5:    bar_rgb_c = 3'b100;
      3'd6:    bar_rgb_c = 3'b001;
      default: bar_rgb_c = 3'b000;
    endcase
    chk_c    = x_pixel[CHECK_LOG2] ^ y_pixel[CHECK_LOG2];
    in_box_c = (11'(x_pixel) >= box_x) && (11'(x_pixel) < box_x + BSIZE) &&
               (11'(y_pixel) >= box_y) && (11'(y_pixel) < box_y + BSIZE);
    r_c = '0;
    g_c = '0;
    b_c = '0;
    case (mode_q)
      2'd0: begin
        r_c = {COLOR_W{bar_rgb_c[2]}};
        g_c = {COLOR_W{bar_rgb_c[1]}};
        b_c = {COLOR_W{bar_rgb_c[0]}};
      end
      2'd1: begin
        r_c = {COLOR_W{chk_c}};
        g_c = {COLOR_W{chk_c}};
        b_c = {COLOR_W{chk_c}};
      end
      2'd2: begin
        r_c = gr_lvl_cur;
        g_c = gr_lvl_cur;
        b_c = gr_lvl_cur;
      end
      default: begin
        r_c = {COLOR_W{in_box_c}};
        g_c = {COLOR_W{in_box_c}};
        b_c = '1;
      end
    endcase
  end

  // Box bounce: clamp to the edge and reverse rather than overshoot
  always_comb begin
    box_x_nxt = box_x;
    dir_x_nxt = dir_x;
    if (dir_x) begin
      if (box_x + STEP >= BX_MAX) begin
        box_x_nxt = BX_MAX;
        dir_x_nxt = 1'b0;
      end else begin
        box_x_nxt = box_x + STEP;
      end
    end else if (box_x <= STEP) begin
      box_x_nxt = '0;
      dir_x_nxt = 1'b1;
    end else begin
      box_x_nxt = box_x - STEP;
    end

    box_y_nxt = box_y;
    dir_y_nxt = dir_y;
    if (dir_y) begin
      if (box_y + STEP >= BY_MAX) begin
        box_y_nxt = BY_MAX;
        dir_y_nxt = 1'b0;
      end else begin
        box_y_nxt = box_y + STEP;
      end
    end else if (box_y <= STEP) begin
      box_y_nxt = '0;
      dir_y_nxt = 1'b1;
    end else begin
      box_y_nxt = box_y - STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      de_out    <= 1'b0;
      r_port    <= '0;
      g_port    <= '0;
      b_port    <= '0;
      frame_cnt <= '0;
      mode_q    <= '0;
      bar_cnt   <= '0;
      bar_idx   <= '0;
      gr_cnt    <= '0;
      gr_lvl    <= '0;
      box_x     <= '0;
      box_y     <= '0;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
    end else begin
      de_out <= DE;
      r_port <= DE ? r_c : '0;
      g_port <= DE ? g_c : '0;
      b_port <= DE ? b_c : '0;
      if (DE) begin
        bar_cnt <= bar_cnt_nxt;
        bar_idx <= bar_idx_nxt;
        gr_cnt  <= gr_cnt_nxt;
        gr_lvl  <= gr_lvl_nxt;
      end
      if (fe_c) begin
        mode_q    <= mode_sel;
        frame_cnt <= frame_cnt + 1'b1;
        if (!pause) begin
          box_x <= box_x_nxt;
          box_y <= box_y_nxt;
          dir_x <= dir_x_nxt;
          dir_y <= dir_y_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed scoreboard bench for vga_pattern_gen with an independent pixel/box/frame model.
module tb_vga_pattern_gen;

  typedef struct packed {
    logic        de;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic [15:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       de_in = 1'b0;
  logic [9:0] x_pixel = '0;
  logic [9:0] y_pixel = '0;
  logic [1:0] mode_sel = '0;
  logic       pause = 1'b0;
  logic       de_out;
  logic [3:0] r_port, g_port, b_port;
  logic [15:0] frame_cnt;

  int n_tests = 0;
  int n_fail = 0;

  exp_t sbq[$];

  // model state
  logic [1:0]  m_mode;
  int          m_bx, m_by;
  logic        m_dx, m_dy;
  logic [15:0] m_fc;
  int          max_bx, max_by;

  vga_pattern_gen dut (
    .clk(clk), .reset(reset), .DE(de_in), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .mode_sel(mode_sel), .pause(pause), .de_out(de_out), .r_port(r_port),
    .g_port(g_port), .b_port(b_port), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pix(input logic [1:0] m, input int x, input int y);
    int idx;
    logic [3:0] f;
    logic [3:0] z;
    f = 4'hF;
    z = 4'h0;
    case (m)
      2'd0: begin
        idx = x / 80;
        if (idx > 7) idx = 7;
        case (idx)
          0: return {f, f, f};
          1: return {f, f, z};
          2: return {z, f, f};
          3: return {z, f, z};
          4: return {f, z, f};
          5: return {f, z, z};
          6: return {z, z, f};
          default: return {z, z, z};
        endcase
      end
      2'd1: return ((((x / 32) + (y / 32)) % 2) == 1) ? {f, f, f} : {z, z, z};
      2'd2: begin
        idx = x / 40;
        if (idx > 15) idx = 15;
        return {4'(idx), 4'(idx), 4'(idx)};
      end
      default: begin
        if (x >= m_bx && x < m_bx + 32 && y >= m_by && y < m_by + 32) return {f, f, f};
        return {z, z, f};
      end
    endcase
  endfunction

  task automatic model_advance_box();
    if (m_dx) begin
      if (m_bx + 2 >= 608) begin m_bx = 608; m_dx = 1'b0; end
      else m_bx = m_bx + 2;
    end else begin
      if (m_bx <= 2) begin m_bx = 0; m_dx = 1'b1; end
      else m_bx = m_bx - 2;
    end
    if (m_dy) begin
      if (m_by + 2 >= 448) begin m_by = 448; m_dy = 1'b0; end
      else m_by = m_by + 2;
    end else begin
      if (m_by <= 2) begin m_by = 0; m_dy = 1'b1; end
      else m_by = m_by - 2;
    end
    if (m_bx > max_bx) max_bx = m_bx;
    if (m_by > max_by) max_by = m_by;
  endtask

  // Drive one pixel clock, push the expected output, then compare it one clock later
  task automatic step(input logic rst, input logic de, input int x, input int y, input string tag);
    exp_t e;
    exp_t got;
    reset   = rst;
    de_in   = de;
    x_pixel = 10'(x);
    y_pixel = 10'(y);
    e = '0;
    if (rst) begin
      m_mode = 2'd0; m_bx = 0; m_by = 0; m_dx = 1'b1; m_dy = 1'b1; m_fc = '0;
    end else begin
      e.de = de;
      if (de) {e.r, e.g, e.b} = pix(m_mode, x, y);
      if (de && x == 639 && y == 479) begin
        m_mode = mode_sel;
        m_fc   = m_fc + 16'd1;
        if (!pause) model_advance_box();
      end
      e.fc = m_fc;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e   = sbq.pop_front();
    got = {de_out, r_port, g_port, b_port, frame_cnt};
    n_tests++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL %s x=%0d y=%0d got de=%b rgb=%h%h%h fc=%h expected de=%b rgb=%h%h%h fc=%h",
             tag, x, y, got.de, got.r, got.g, got.b, got.fc, e.de, e.r, e.g, e.b, e.fc);
    end
  endtask

  task automatic frame_end(input string tag);
    step(1'b0, 1'b1, 639, 479, tag);
  endtask

  task automatic box_probes();
    int bx, by;
    bx = m_bx;
    by = m_by;
    step(1'b0, 1'b1, bx, by, "box_tl");
    if (!(bx + 31 == 639 && by + 31 == 479)) step(1'b0, 1'b1, bx + 31, by + 31, "box_br");
    if (bx + 32 < 640) step(1'b0, 1'b1, bx + 32, by, "box_right_out");
    if (by > 0) step(1'b0, 1'b1, bx, by - 1, "box_above_out");
    if (bx > 0) step(1'b0, 1'b1, bx - 1, by + 5, "box_left_out");
  endtask

  initial begin
    int saved_x, saved_y;
    m_mode = 2'd0; m_bx = 0; m_by = 0; m_dx = 1'b1; m_dy = 1'b1; m_fc = '0;
    max_bx = 0; max_by = 0;

    // T1: reset held with DE high, then pixel (0,0) in bars
    mode_sel = 2'd3;
    repeat (3) step(1'b1, 1'b1, 0, 0, "t1_reset");
    mode_sel = 2'd0;
    step(1'b0, 1'b1, 0, 0, "t1_px00");

    // T2: full bar line
    for (int x = 0; x < 640; x++) step(1'b0, 1'b1, x, 10, "t2_bars");
    step(1'b0, 1'b0, 0, 11, "t2_blank");

    // T3: mid-frame mode change must not take effect until frame end
    for (int x = 0; x < 640; x++) begin
      if (x == 300) mode_sel = 2'd1;
      step(1'b0, 1'b1, x, 200, "t3_bars_hold");
    end
    frame_end("t3_fe");
    step(1'b0, 1'b1, 32, 0, "t3_chk_32_0");
    step(1'b0, 1'b1, 0, 0, "t3_chk_0_0");
    step(1'b0, 1'b1, 40, 40, "t3_chk_40_40");

    // T4: grey ramp with DE gaps
    mode_sel = 2'd2;
    frame_end("t4_fe");
    for (int x = 0; x < 640; x++) begin
      step(1'b0, 1'b1, x, 5, "t4_ramp");
      if (x % 97 == 50) step(1'b0, 1'b0, x, 5, "t4_gap");
    end

    // T5: bouncing box over 400 frames
    mode_sel = 2'd3;
    frame_end("t5_fe_enter");
    for (int f = 0; f < 400; f++) begin
      box_probes();
      frame_end("t5_fe");
    end
    box_probes();

    // T6: pause freezes the box while frames still count
    pause = 1'b1;
    saved_x = m_bx;
    saved_y = m_by;
    for (int f = 0; f < 5; f++) begin
      frame_end("t6_fe_paused");
      step(1'b0, 1'b1, saved_x, saved_y, "t6_paused_tl");
      if (saved_x > 0) step(1'b0, 1'b1, saved_x - 1, saved_y, "t6_paused_left");
    end
    pause = 1'b0;
    while (m_fc != 16'hFFFF) frame_end("t6_count");
    frame_end("t6_wrap");

    // Reset in the middle of a box frame
    step(1'b0, 1'b1, 100, 100, "rst_pre");
    step(1'b1, 1'b1, 101, 100, "rst_mid");
    step(1'b0, 1'b1, 0, 0, "rst_after_px00");
    step(1'b0, 1'b1, 1, 0, "rst_after_px10");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
